waypoint_route_sequencer: RTL and testbench

- Buffers an ordered route of up to DEPTH polar target locations, each taken from the switch-driven target location selector.
- Presents the targets one at a time to the navigation datapath using a valid/ready handshake.
- Advances to the next target on the datapath's arrival pulse, with a per-leg timeout and abort.
- Sits between the target selector / user buttons and the path-planning FSM in the main FPGA.

---
 rtl/waypoint_route_sequencer.sv | 167 ++++++++++++++++
 tb/tb_waypoint_route_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/waypoint_route_sequencer.sv
// Route queue of polar waypoints. Targets go to the navigation datapath one at a time
// over valid/ready, and the route advances on arrival pulses with a per-leg timeout.
module waypoint_route_sequencer #(
    parameter int          DEPTH          = 4,
    parameter int          TIMEOUT_CYCLES = 270000000,
    parameter int          TIMER_WIDTH    = 29,
    parameter logic [3:0]  MAX_THETA      = 4'hC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] selected_location,
    input  logic        add_waypoint,
    input  logic        clear_route,
    input  logic        start_route,
    input  logic        abort,
    output logic [11:0] target_location,
    output logic        target_valid,
    input  logic        target_ready,
    input  logic        arrived,
    output logic        route_active,
    output logic [2:0]  current_index,
    output logic [3:0]  waypoint_count,
    output logic        queue_full,
    output logic        reject,
    output logic        route_done,
    output logic        leg_timeout
);

    localparam int                     IDX_W      = $clog2(DEPTH);
    localparam logic [3:0]             FULL_COUNT = 4'(DEPTH);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_TRAVEL,
        S_NEXT
    } state_t;

    state_t                 r_state;
    logic [11:0]            r_queue [DEPTH];
    logic [3:0]             r_count;
    logic [2:0]             r_index;
    logic [11:0]            r_target;
    logic                   r_valid;
    logic                   r_active;
    logic                   r_reject;
    logic                   r_done;
    logic                   r_timeout;
    logic [TIMER_WIDTH-1:0] r_timer;

    logic       w_idle;
    logic       w_clear;
    logic       w_add_ok;
    logic       w_reject;
    logic [2:0] w_index_inc;
    logic       w_last_leg;

    assign w_idle      = (r_state == S_IDLE);
    // Clear beats a simultaneous add, and the dropped add is not a reject.
    assign w_clear     = clear_route && w_idle;
    assign w_add_ok    = add_waypoint && w_idle && !w_clear && (r_count != FULL_COUNT)
                         && (selected_location[11:8] <= MAX_THETA)
                         && (selected_location[7:0] != 8'd0);
    assign w_reject    = add_waypoint && !w_clear && !w_add_ok;
    assign w_index_inc = r_index + 3'd1;
    assign w_last_leg  = (({1'b0, r_index} + 4'd1) == r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_queue[i] <= 12'd0;
            end
        end else if (w_add_ok) begin
            r_queue[r_count[IDX_W-1:0]] <= selected_location;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_index   <= 3'd0;
            r_target  <= 12'd0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_reject  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_reject <= w_reject;
            r_done   <= 1'b0;

            if (w_clear) begin
                r_count   <= 4'd0;
                r_timeout <= 1'b0;
            end else if (w_add_ok) begin
                r_count <= r_count + 4'd1;
            end

            if (!w_idle && abort) begin
                r_state  <= S_IDLE;
                r_valid  <= 1'b0;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_route && (r_count != 4'd0) && !w_clear) begin
                            r_state   <= S_ISSUE;
                            r_index   <= 3'd0;
                            r_target  <= r_queue[0];
                            r_valid   <= 1'b1;
                            r_active  <= 1'b1;
                            r_timeout <= 1'b0;
                            r_timer   <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (target_ready) begin
                            r_state <= S_TRAVEL;
                            r_valid <= 1'b0;
                            r_timer <= '0;
                        end
                    end
                    S_TRAVEL: begin
                        // Arrival on the final timer cycle still counts as arrival.
                        if (arrived) begin
                            r_state <= S_NEXT;
                        end else if (r_timer == TIMER_LAST) begin
                            r_state   <= S_IDLE;
                            r_active  <= 1'b0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (w_last_leg) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_index  <= w_index_inc;
                            r_target <= r_queue[w_index_inc[IDX_W-1:0]];
                            r_valid  <= 1'b1;
                            r_timer  <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign target_location = r_target;
    assign target_valid    = r_valid;
    assign route_active    = r_active;
    assign current_index   = r_index;
    assign waypoint_count  = r_count;
    assign queue_full      = (r_count == FULL_COUNT);
    assign reject          = r_reject;
    assign route_done      = r_done;
    assign leg_timeout     = r_timeout;

endmodule

// File: tb/tb_waypoint_route_sequencer.sv
// Self-checking bench for waypoint_route_sequencer: table-driven enqueue vectors,
// then hand-written route sequences with a scoreboard of expected targets.
module tb_waypoint_route_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] selected_location;
    logic        add_waypoint;
    logic        clear_route;
    logic        start_route;
    logic        abort;
    logic [11:0] target_location;
    logic        target_valid;
    logic        target_ready;
    logic        arrived;
    logic        route_active;
    logic [2:0]  current_index;
    logic [3:0]  waypoint_count;
    logic        queue_full;
    logic        reject;
    logic        route_done;
    logic        leg_timeout;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic [11:0] sb [$];

    waypoint_route_sequencer #(
        .DEPTH(4),
        .TIMEOUT_CYCLES(50),
        .TIMER_WIDTH(29),
        .MAX_THETA(4'hC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .selected_location(selected_location),
        .add_waypoint(add_waypoint),
        .clear_route(clear_route),
        .start_route(start_route),
        .abort(abort),
        .target_location(target_location),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .arrived(arrived),
        .route_active(route_active),
        .current_index(current_index),
        .waypoint_count(waypoint_count),
        .queue_full(queue_full),
        .reject(reject),
        .route_done(route_done),
        .leg_timeout(leg_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (route_done === 1'b1) done_pulses++;
    end

    typedef struct {
        logic [11:0] loc;
        logic        add;
        logic        clr;
        logic        exp_reject;
        logic [3:0]  exp_count;
        logic        exp_full;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Wait (bounded) for target_valid, compare against scoreboard, then accept it.
    task automatic do_handshake(input string name);
        int n;
        logic [11:0] exp;
        n = 0;
        while (target_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (target_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: target_valid never rose, got %b, expected 1", name, target_valid);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected target %0h, expected none", name, target_location);
        end else begin
            exp = sb.pop_front();
            check({name, "_loc"}, 32'(target_location), 32'(exp));
        end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(target_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0]  = '{12'h618, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[1]  = '{12'h120, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[2]  = '{12'h730, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0};
        vecs[3]  = '{12'hB40, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1};
        vecs[4]  = '{12'h555, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1};
        vecs[5]  = '{12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[6]  = '{12'hD10, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[7]  = '{12'h400, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[8]  = '{12'h618, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{12'h618, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[10] = '{12'h120, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0};

        reset = 1'b1;
        selected_location = 12'd0;
        add_waypoint = 1'b0;
        clear_route = 1'b0;
        start_route = 1'b0;
        abort = 1'b0;
        target_ready = 1'b0;
        arrived = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(target_valid), 32'd0);
        check("rst_active", 32'(route_active), 32'd0);
        check("rst_count", 32'(waypoint_count), 32'd0);
        check("rst_loc", 32'(target_location), 32'd0);
        check("rst_timeout", 32'(leg_timeout), 32'd0);

        // Enqueue / reject / clear vectors.
        for (int i = 0; i < 11; i++) begin
            selected_location = vecs[i].loc;
            add_waypoint = vecs[i].add;
            clear_route = vecs[i].clr;
            tick();
            add_waypoint = 1'b0;
            clear_route = 1'b0;
            check($sformatf("vec%0d_reject", i), 32'(reject), 32'(vecs[i].exp_reject));
            check($sformatf("vec%0d_count", i), 32'(waypoint_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_full", i), 32'(queue_full), 32'(vecs[i].exp_full));
        end
        tick();
        check("reject_one_cycle", 32'(reject), 32'd0);

        // Two-leg route with a stalled ready.
        d0 = done_pulses;
        sb.push_back(12'h618);
        sb.push_back(12'h120);
        start_route = 1'b1;
        tick();
        start_route = 1'b0;
        check("start_valid", 32'(target_valid), 32'd1);
        check("start_active", 32'(route_active), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d_valid", i), 32'(target_valid), 32'd1);
            check($sformatf("stall%0d_loc", i), 32'(target_location), 32'h618);
        end
        do_handshake("leg0");
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check("next_valid_low", 32'(target_valid), 32'd0);
        tick();
        check("leg1_valid_2cyc", 32'(target_valid), 32'd1);
        check("leg1_index", 32'(current_index), 32'd1);
        do_handshake("leg1");
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check("done_not_yet", 32'(route_done), 32'd0);
        tick();
        check("route_done", 32'(route_done), 32'd1);
        check("done_active", 32'(route_active), 32'd0);
        tick();
        check("done_one_cycle", 32'(route_done), 32'd0);
        check("done_pulse_count", 32'(done_pulses - d0), 32'd1);

        // Leg timeout after 50 cycles in TRAVEL.
        d0 = done_pulses;
        sb.push_back(12'h618);
        start_route = 1'b1;
        tick();
        start_route = 1'b0;
        do_handshake("to_leg0");
        for (int i = 0; i < 49; i++) tick();
        check("to_still_active", 32'(route_active), 32'd1);
        check("to_not_yet", 32'(leg_timeout), 32'd0);
        tick();
        check("to_active_low", 32'(route_active), 32'd0);
        check("to_sticky", 32'(leg_timeout), 32'd1);
        tick();
        check("to_sticky_hold", 32'(leg_timeout), 32'd1);
        check("to_no_done", 32'(done_pulses - d0), 32'd0);

        // Replay from index 0, then abort during leg 1.
        sb.push_back(12'h618);
        sb.push_back(12'h120);
        start_route = 1'b1;
        tick();
        start_route = 1'b0;
        check("replay_timeout_clr", 32'(leg_timeout), 32'd0);
        check("replay_index", 32'(current_index), 32'd0);
        do_handshake("rp_leg0");
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        do_handshake("rp_leg1");
        tick();
        tick();
        d0 = done_pulses;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_active", 32'(route_active), 32'd0);
        check("abort_valid", 32'(target_valid), 32'd0);
        check("abort_count", 32'(waypoint_count), 32'd2);
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        tick();
        tick();
        check("idle_arr_active", 32'(route_active), 32'd0);
        check("idle_arr_valid", 32'(target_valid), 32'd0);
        check("idle_arr_index", 32'(current_index), 32'd1);
        check("abort_no_done", 32'(done_pulses - d0), 32'd0);

        // Reset while in ISSUE.
        sb.push_back(12'h618);
        start_route = 1'b1;
        tick();
        start_route = 1'b0;
        check("rst2_valid_before", 32'(target_valid), 32'd1);
        check("rst2_loc_before", 32'(target_location), 32'(sb.pop_front()));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_valid", 32'(target_valid), 32'd0);
        check("rst2_active", 32'(route_active), 32'd0);
        check("rst2_count", 32'(waypoint_count), 32'd0);
        check("rst2_loc", 32'(target_location), 32'd0);
        check("rst2_index", 32'(current_index), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
